// File: rtl/fpu_pkg.sv
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared constants, operand format and encoder state type for the
//            FPU operand encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  localparam int EXP_W  = 6;
  localparam int FRAC_W = 25;

  localparam logic [EXP_W-1:0] EXP_BIAS = 6'd31;
  // Exponent for a magnitude whose bit31 is already set (2^31 -> 31 + 31).
  localparam logic [EXP_W-1:0] EXP_INIT = 6'd62;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/fpu_int_normalizer.sv
// ============================================================================
// Module   : fpu_int_normalizer
// Purpose  : One encoder lane: magnitude/exponent capture, serial left
//            normalisation and pack (truncate, or round-to-nearest-even when
//            FPU_ENC_ROUND_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_int_normalizer
  import fpu_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             norm,
  input  logic             pack,
  input  logic [INT_W-1:0] int_in,
  output logic             done,
  output logic [31:0]      op_out,
  output logic             inexact_out
);

  logic             r_sign;
  logic [INT_W-1:0] r_mag;
  logic [EXP_W-1:0] r_exp;
  fp_t              r_op;
  logic             r_inexact;

  logic [INT_W-1:0]  w_abs;
  logic              w_done;
  logic              w_inexact;
  logic [FRAC_W-1:0] w_frac;
  logic [EXP_W-1:0]  w_exp;
  fp_t               w_packed;

  // Unary minus keeps -2^31 as 0x80000000, which is the correct unsigned magnitude.
  assign w_abs     = int_in[INT_W-1] ? (-int_in) : int_in;
  assign w_done    = r_mag[INT_W-1] | (r_mag == '0);
  assign w_inexact = |r_mag[5:0];

`ifdef FPU_ENC_ROUND_EN
  logic              w_round_up;
  logic [FRAC_W:0]   w_frac_sum;

  assign w_round_up = r_mag[5] & ((|r_mag[4:0]) | r_mag[6]);
  assign w_frac_sum = {1'b0, r_mag[30:6]} + {{FRAC_W{1'b0}}, w_round_up};
  assign w_frac     = w_frac_sum[FRAC_W-1:0];
  assign w_exp      = r_exp + {{(EXP_W-1){1'b0}}, w_frac_sum[FRAC_W]};
`else
  assign w_frac     = r_mag[30:6];
  assign w_exp      = r_exp;
`endif

  always_comb begin
    w_packed = '0;
    if (r_mag != '0) begin
      w_packed.sign = r_sign;
      w_packed.exp  = w_exp;
      w_packed.frac = w_frac;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_exp     <= '0;
      r_op      <= '0;
      r_inexact <= 1'b0;
    end else begin
      if (load) begin
        r_sign <= int_in[INT_W-1];
        r_mag  <= w_abs;
        r_exp  <= EXP_INIT;
      end else if (norm && !w_done) begin
        r_mag  <= {r_mag[INT_W-2:0], 1'b0};
        r_exp  <= r_exp - 6'd1;
      end
      if (pack) begin
        r_op      <= w_packed;
        r_inexact <= w_inexact;
      end
    end
  end

  assign done        = w_done;
  assign op_out      = r_op;
  assign inexact_out = r_inexact;

endmodule

`default_nettype wire

// File: rtl/fpu_operand_encoder.sv
// ============================================================================
// Module   : fpu_operand_encoder
// Purpose  : Encodes two signed integers into FPU float operands with a
//            valid/ready handshake. Optional macro: FPU_ENC_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_operand_encoder
  import fpu_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] int_a_in,
  input  logic [INT_W-1:0] int_b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      op_A_out,
  output logic [31:0]      op_B_out,
  output logic [1:0]       inexact_out
);

  enc_state_t r_state;
  logic       r_out_valid;

  logic w_load;
  logic w_norm;
  logic w_pack;
  logic w_done_a;
  logic w_done_b;
  logic w_inexact_a;
  logic w_inexact_b;

  assign w_load = (r_state == IDLE) & in_valid;
  assign w_norm = (r_state == NORM);
  assign w_pack = (r_state == PACK);

  fpu_int_normalizer #(.INT_W(INT_W)) u_lane_a (
    .clock       (clock),
    .reset       (reset),
    .load        (w_load),
    .norm        (w_norm),
    .pack        (w_pack),
    .int_in      (int_a_in),
    .done        (w_done_a),
    .op_out      (op_A_out),
    .inexact_out (w_inexact_a)
  );

  fpu_int_normalizer #(.INT_W(INT_W)) u_lane_b (
    .clock       (clock),
    .reset       (reset),
    .load        (w_load),
    .norm        (w_norm),
    .pack        (w_pack),
    .int_in      (int_b_in),
    .done        (w_done_b),
    .op_out      (op_B_out),
    .inexact_out (w_inexact_b)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) r_state <= NORM;
        NORM: if (w_done_a && w_done_b) r_state <= PACK;
        PACK: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign inexact_out = {w_inexact_b, w_inexact_a};

endmodule

`default_nettype wire

// File: tb/tb_fpu_operand_encoder.sv
// ============================================================================
// Module   : tb_fpu_operand_encoder
// Purpose  : Self-checking bench for fpu_operand_encoder (honours
//            FPU_ENC_ROUND_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_operand_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] int_a_in = '0;
  logic [31:0] int_b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] op_A_out;
  logic [31:0] op_B_out;
  logic [1:0]  inexact_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_a   = '0;
  logic [31:0] exp_b   = '0;
  logic [1:0]  exp_inx = '0;

  always #5 clock = ~clock;

  fpu_operand_encoder #(.INT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .int_a_in    (int_a_in),
    .int_b_in    (int_b_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op_A_out    (op_A_out),
    .op_B_out    (op_B_out),
    .inexact_out (inexact_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Leading zeros of |x| in 32 bits (0 for x = 0).
  function automatic int lz_of(input logic [31:0] x);
    longint m;
    m = x[31] ? -longint'($signed(x)) : longint'(x);
    if (m == 0) return 0;
    for (int i = 31; i >= 0; i--) if (m >= (64'sd1 <<< i)) return 31 - i;
    return 0;
  endfunction

  // Returns {inexact, encoding} from the value of x.
  function automatic logic [32:0] model(input logic [31:0] x);
    longint      m;
    int          lz;
    int          e;
    logic [31:0] nm;
    int          frac;
    logic        inx;
    m = x[31] ? -longint'($signed(x)) : longint'(x);
    if (m == 0) return 33'd0;
    lz   = lz_of(x);
    e    = 62 - lz;
    nm   = 32'(m << lz);
    frac = int'(nm[30:6]);
    inx  = (nm[5:0] != 6'd0);
`ifdef FPU_ENC_ROUND_EN
    if (nm[5] && ((nm[4:0] != 5'd0) || nm[6])) begin
      frac = frac + 1;
      if (frac == (1 << 25)) begin
        frac = 0;
        e    = e + 1;
      end
    end
`endif
    return {inx, x[31], 6'(e), 25'(frac)};
  endfunction

  // Outputs must match the model every cycle out_valid is high.
  always @(negedge clock) begin
    if (reset && out_valid) begin
      chk("op_A", op_A_out, exp_a);
      chk("op_B", op_B_out, exp_b);
      chk("inexact", {30'd0, inexact_out}, {30'd0, exp_inx});
    end
  end

  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [32:0] ma;
    logic [32:0] mb;
    int          lat;
    ma  = model(a);
    mb  = model(b);
    lat = ((lz_of(a) > lz_of(b)) ? lz_of(a) : lz_of(b)) + 2;
    @(negedge clock);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    int_a_in  = a;
    int_b_in  = b;
    out_ready = (hold == 0);
    @(posedge clock);
    #1;
    exp_a    = ma[31:0];
    exp_b    = mb[31:0];
    exp_inx  = {mb[32], ma[32]};
    in_valid = 1'b0;
    int_a_in = $urandom;
    int_b_in = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clock);
      #1;
      chk("valid_timing", {31'd0, out_valid}, {31'd0, (k == lat)});
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      in_valid = 1'b1;
      int_a_in = $urandom;
      int_b_in = $urandom;
      @(posedge clock);
      #1;
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      chk("valid_held", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    // Pin the model against hand-derived encodings.
    chk("model_1", model(32'd1), 33'h03E000000);
    chk("model_2", model(32'd2), 33'h040000000);
    chk("model_0", model(32'd0), 33'h000000000);
    chk("model_m1", model(32'hFFFFFFFF), 33'h0BE000000);
    chk("model_min", model(32'h80000000), 33'h0FC000000);
`ifdef FPU_ENC_ROUND_EN
    chk("model_max", model(32'h7FFFFFFF), 33'h17C000000);
`else
    chk("model_max", model(32'h7FFFFFFF), 33'h17BFFFFFF);
`endif
    chk("model_tie", model(32'h40000010), 33'h17A000000);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_A", op_A_out, 32'd0);
    chk("rst_op_B", op_B_out, 32'd0);
    chk("rst_inexact", {30'd0, inexact_out}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_pair(32'd1, 32'd2, 0);
    run_pair(32'd0, 32'hFFFFFFFF, 0);
    run_pair(32'h80000000, 32'h7FFFFFFF, 0);
    run_pair(32'h40000010, 32'd1, 0);
    run_pair(32'h00012345, 32'hFFF00001, 5);

    // Reset during NORM.
    @(negedge clock);
    in_valid = 1'b1;
    int_a_in = 32'd1;
    int_b_in = 32'd2;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_op_A", op_A_out, 32'd0);
    chk("abort_op_B", op_B_out, 32'd0);
    chk("abort_inexact", {30'd0, inexact_out}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_pair(32'd1, 32'd2, 0);

    for (int t = 0; t < 40; t++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if ($urandom_range(0, 9) == 0) ra = 32'd0;
      if ($urandom_range(0, 9) == 0) rb = 32'h80000000;
      run_pair(ra, rb, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
